mem_arbiter: RTL and testbench

Single-port memory arbiter sitting between the instruction-fetch and data request paths and the unified RAM. Each cycle it grants the RAM port to at most one requester and forwards address, data and enables. It returns per-requester wait signals so the request unit and pipeline stall until their own access completes. Data accesses win ties, and a starvation counter bounds how long instruction fetch can be locked out.

---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_grant_select.sv | 19 +
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-path types: word, RAM handshake state, arbiter state and RAM request payload.
package cpu_types_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned TCNT_W   = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Decoded by the trace/debug monitor.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arbstate_t;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } ram_req_t;

  // An access finishes on ACCESS or ERROR; ERROR additionally flags a fault.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between request unit, arbiter and unified RAM.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  logic      dREN;
  logic      dWEN;
  word_t     iaddr;
  word_t     daddr;
  word_t     dstore;
  word_t     iload;
  word_t     dload;
  logic      iwait;
  logic      dwait;
  logic      err;
  ram_req_t  ram_req;
  word_t     ramload;
  ramstate_t ramstate;

  modport arb (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iload, dload, iwait, dwait, err, ram_req
  );

  modport req (
    output iREN, dREN, dWEN, iaddr, daddr, dstore,
    input  iload, dload, iwait, dwait, err
  );

  modport ram (
    input  ram_req,
    output ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter_grant_select.sv
// IDLE priority decision: data wins ties unless fetch has been starved STARVE_LIMIT times.
module mem_arbiter_grant_select
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                dreq,
  input  logic                ireq,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_d_c,
  output logic                grant_i_c
);

  always_comb begin
    grant_d_c = dreq && ((starve_cnt < STARVE_W'(STARVE_LIMIT)) || !ireq);
    grant_i_c = ireq && !grant_d_c;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data paths with starvation bound and timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  arbstate_t           state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                err_q, err_d;

  logic dreq;
  logic done;
  logic grant_d_c;
  logic grant_i_c;

  assign dreq = dREN | dWEN;
  assign done = ram_done(ramstate);
  assign err  = err_q;

  mem_arbiter_grant_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant_select (
    .dreq       (dreq),
    .ireq       (iREN),
    .starve_cnt (starve_cnt_q),
    .grant_d_c  (grant_d_c),
    .grant_i_c  (grant_i_c)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tcnt_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tcnt_q       <= tcnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tcnt_d       = tcnt_q;
    err_d        = err_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = iaddr;
    ramstore     = dstore;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = ramload;
    dload        = ramload;

    unique case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          state_d = DGRANT;
          tcnt_d  = '0;
        end else if (grant_i_c) begin
          state_d = IGRANT;
          tcnt_d  = '0;
        end
      end

      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (done) begin
            iwait        = 1'b0;
            state_d      = IDLE;
            starve_cnt_d = '0;
            if (ramstate == ERROR) err_d = 1'b1;
          end else begin
            if (tcnt_q != '1) tcnt_d = tcnt_q + TCNT_W'(1);
            if (tcnt_d == TCNT_W'(TIMEOUT)) err_d = 1'b1;
          end
        end
      end

      DGRANT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          // Write wins when both enables are set.
          ramWEN  = dWEN;
          ramREN  = !dWEN;
          ramaddr = daddr;
          if (done) begin
            dwait   = 1'b0;
            state_d = IDLE;
            if (iREN && (starve_cnt_q != '1)) starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            if (ramstate == ERROR) err_d = 1'b1;
          end else begin
            if (tcnt_q != '1) tcnt_d = tcnt_q + TCNT_W'(1);
            if (tcnt_d == TCNT_W'(TIMEOUT)) err_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 15;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  word_t     iload, dload, ramaddr, ramstore;
  logic      iwait, dwait, ramREN, ramWEN, err;
  ramstate_t ramstate;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 data), completions lost by fetch, grant age, fault.
  int owner;
  int starved;
  int age;
  bit fault;
  int done_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0; starved = 0; age = 0; fault = 0;
  endtask

  task automatic check_outputs();
    bit    want_d = dREN || dWEN;
    bit    fin    = (ramstate == ACCESS) || (ramstate == ERROR);
    logic  e_ren  = 1'b0;
    logic  e_wen  = 1'b0;
    logic  e_iw   = 1'b1;
    logic  e_dw   = 1'b1;
    word_t e_addr = iaddr;
    if (owner == 1 && iREN) begin
      e_ren = 1'b1;
      if (fin) e_iw = 1'b0;
    end
    if (owner == 2 && want_d) begin
      e_wen  = dWEN;
      e_ren  = !dWEN;
      e_addr = daddr;
      if (fin) e_dw = 1'b0;
    end
    check("ramREN", 32'(ramREN), 32'(e_ren));
    check("ramWEN", 32'(ramWEN), 32'(e_wen));
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, dstore);
    check("iwait", 32'(iwait), 32'(e_iw));
    check("dwait", 32'(dwait), 32'(e_dw));
    check("err", 32'(err), 32'(fault));
    if (!e_iw) check("iload", iload, ramload);
    if (!e_dw) check("dload", dload, ramload);
    if (iwait === 1'b0) done_q.push_back(1);
    if (dwait === 1'b0) done_q.push_back(2);
  endtask

  task automatic grant_aged();
    if (age < 255) age++;
    if (age == int'(TIMEOUT)) fault = 1;
  endtask

  task automatic model_tick();
    bit want_d = dREN || dWEN;
    bit fin    = (ramstate == ACCESS) || (ramstate == ERROR);
    case (owner)
      0: begin
        if (want_d && (starved < int'(STARVE_LIMIT) || !iREN)) begin owner = 2; age = 0; end
        else if (iREN) begin owner = 1; age = 0; end
      end
      1: begin
        if (!iREN) owner = 0;
        else if (fin) begin
          owner = 0; starved = 0;
          if (ramstate == ERROR) fault = 1;
        end else grant_aged();
      end
      default: begin
        if (!want_d) owner = 0;
        else if (fin) begin
          owner = 0;
          if (iREN) starved = (starved < 15) ? starved + 1 : 15;
          if (ramstate == ERROR) fault = 1;
        end else grant_aged();
      end
    endcase
  endtask

  // Inputs are set just after a falling edge; outputs checked 1 time unit later.
  task automatic step();
    #1;
    check_outputs();
    @(posedge CLK);
    if (nRST) model_tick();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    idle_inputs();
    step();
    step();
    nRST = 1'b1;
  endtask

  int exp_seq[6] = '{2, 2, 2, 2, 1, 2};
  int r;

  initial begin
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    nRST  = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge CLK);
    do_reset();

    // Quiet bus after reset.
    repeat (10) step();

    // Single fetch completing on its first grant cycle.
    iREN = 1'b1; iaddr = 32'h40;
    step();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    check("t2_iwait", 32'(iwait), 32'd0);
    check("t2_iload", iload, 32'hDEADBEEF);
    check("t2_addr", ramaddr, 32'h40);
    step();
    iREN = 1'b0; ramstate = FREE;
    step();

    // Simultaneous fetch and data write: data first.
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234; ramstate = ACCESS;
    step();
    #1;
    check("t3_wen", 32'(ramWEN), 32'd1);
    check("t3_ren", 32'(ramREN), 32'd0);
    check("t3_addr", ramaddr, 32'h100);
    check("t3_store", ramstore, 32'h1234);
    check("t3_dwait", 32'(dwait), 32'd0);
    step();
    dWEN = 1'b0;
    step();
    #1;
    check("t3_ifetch_ren", 32'(ramREN), 32'd1);
    check("t3_ifetch_addr", ramaddr, 32'h40);
    check("t3_iwait", 32'(iwait), 32'd0);
    step();
    idle_inputs();
    step();

    // Starvation bound: four data completions then one fetch.
    do_reset();
    done_q.delete();
    iREN = 1'b1; dREN = 1'b1; ramstate = ACCESS;
    repeat (12) step();
    check("t4_count", 32'(done_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < done_q.size()) check($sformatf("t4_order%0d", i), 32'(done_q[i]), 32'(exp_seq[i]));
    idle_inputs();
    step();

    // Timeout: err rises once 15 grant cycles have elapsed without completion.
    do_reset();
    dREN = 1'b1; ramstate = BUSY;
    step();
    for (int g = 1; g <= 20; g++) begin
      #1;
      check($sformatf("t5_err_g%0d", g), 32'(err), 32'(g >= 16));
      check($sformatf("t5_dwait_g%0d", g), 32'(dwait), 32'd1);
      step();
    end
    ramstate = ACCESS;
    #1;
    check("t5_dwait_access", 32'(dwait), 32'd0);
    step();
    idle_inputs();
    step();

    // Flush of a data grant, then async reset in the middle of a fetch grant.
    dREN = 1'b1;
    step();
    dREN = 1'b0; ramstate = BUSY;
    #1;
    check("t6_flush_dwait", 32'(dwait), 32'd1);
    check("t6_flush_ren", 32'(ramREN), 32'd0);
    step();
    iREN = 1'b1;
    step();
    #1;
    check("t6_igrant_ren", 32'(ramREN), 32'd1);
    check("t6_err_before", 32'(err), 32'd1);
    nRST = 1'b0;
    model_reset();
    #1;
    check("t6_rst_ren", 32'(ramREN), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    check("t6_rst_iwait", 32'(iwait), 32'd1);
    step();
    idle_inputs();
    step();
    nRST = 1'b1;

    // Randomized traffic.
    repeat (4) begin
      do_reset();
      repeat (150) begin
        iREN   = ($urandom_range(0, 3) != 0);
        dREN   = ($urandom_range(0, 1) != 0);
        dWEN   = ($urandom_range(0, 3) == 0);
        iaddr  = $urandom;
        daddr  = $urandom;
        dstore = $urandom;
        ramload = $urandom;
        r = $urandom_range(0, 63);
        if (r == 0)       ramstate = ERROR;
        else if (r < 20)  ramstate = BUSY;
        else if (r < 30)  ramstate = FREE;
        else              ramstate = ACCESS;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
